ss_meas_ctrl: RTL and testbench
===============================

// Module: ss_meas_ctrl
// PURPOSE
//  Clocked sequencer for steady-state measurement. After a start pulse it waits a settle time,
//  then requests digitized samples at a fixed interval and tracks them against a held reference
//  level. It declares steady-state after NO_BUFF consecutive in-tolerance samples, or timeout
//  after a sample budget. Sits between test/calibration control and a shared sampler (ADC, meter).
// PARAMETERS
//  DW       16  sample width, signed two's complement
//  CW       16  width of timing/sample counters and cfg_ts/cfg_ti/cfg_max
//  NO_BUFF  4   consecutive in-tolerance samples required (>=1)
// PORTS
//  clk        in   1        clock, rising edge
//  rstn       in   1        synchronous active-low reset
//  start      in   1        pulse; begin a measurement (IDLE/DONE/TIMEOUT only)
//  abort      in   1        return to IDLE from any state
//  cfg_ts     in   CW       settle cycles before first request
//  cfg_ti     in   CW       cycles between requests (0 treated as 1)
//  cfg_tol    in   DW       tolerance, unsigned magnitude
//  cfg_max    in   CW       max samples incl. first (0 = no timeout)
//  smp_req    out  1        sample request, held until accepted
//  smp_vld    in   1        sample valid; accepted when smp_req&smp_vld
//  smp_data   in   DW       sample value
//  busy       out  1        high in SETTLE/WAIT/REQ
//  steady     out  1        steady-state detected (sticky)
//  timeout    out  1        budget exhausted (sticky)
//  ss_value   out  DW       reference level; valid when steady
//  n_samples  out  CW       samples accepted this run (saturates)
// BEHAVIOUR
//  Reset: synchronous on rstn=0; all outputs 0, state IDLE, counters and reference 0.
//  cfg_* latched on the start-accept cycle; changes mid-run ignored.
//  States: IDLE, SETTLE, WAIT, REQ, DONE, TOUT.
//   IDLE  -start-> SETTLE (cfg_ts>0) else WAIT; clears steady/timeout/n_samples/hit count.
//   SETTLE counts cfg_ts cycles -> WAIT.   WAIT counts max(cfg_ti,1) cycles -> REQ.
//   REQ: smp_req=1 (registered). On smp_vld: accept smp_data, smp_req drops next cycle, evaluate:
//    - first sample of run: ref<=data, hit<=0 -> WAIT.
//    - |data-ref|<=cfg_tol: hit++, ref kept; hit==NO_BUFF -> DONE.
//    - else hit<=0, ref<=data.
//    - then if cfg_max!=0 and n_samples==cfg_max -> TOUT, else WAIT.
//   DONE: steady=1, ss_value=ref, held. TOUT: timeout=1, held. Both accept start as a new run.
//  Difference computed in DW+1 bits signed, absolute value compared unsigned; no overflow at
//   full-scale extremes (e.g. 0x7FFF vs 0x8000 -> |diff|=65535).
//  Latency: steady/timeout assert the cycle after the accepting smp_vld.
//  Boundaries:
//   - NO_BUFF-th hit on the cfg_max-th sample: DONE wins, timeout stays 0.
//   - abort and start same cycle: abort wins -> IDLE, flags cleared, smp_req=0 next cycle.
//   - start while busy: ignored.  smp_vld outside REQ: ignored.
//   - rstn low mid-run: IDLE next edge, smp_req drops, no sample evaluated.
//   - n_samples saturates at 2^CW-1; cfg_max=0 runs until steady or abort.
// TESTING
//  1 cfg_ts=10,cfg_ti=5,tol=2; samples 100,150,151,152,150,149 -> steady after 6th, ss_value=150, n_samples=6.
//  2 cfg_max=4, samples 0,10,20,30 -> timeout=1 after 4th, steady=0, smp_req stays 0.
//  3 NO_BUFF=4, cfg_max=5, samples 7,7,7,7,7 -> steady=1, timeout=0 (tie rule).
//  4 smp_vld delayed 3 cycles in REQ -> smp_req held 3 cycles, one sample accepted; stray smp_vld in WAIT ignored.
//  5 abort in REQ, and abort+start same cycle -> IDLE, busy=0, flags 0; start during SETTLE ignored.
//  6 samples 0x7FFF then 0x8000, tol=100 -> not in tolerance, ref=0x8000, hit=0; rstn=0 mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/ss_meas_ctrl.sv
// ---------------------------------------------------------------------------
// ss_meas_ctrl
//   Steady-state measurement sequencer. A start pulse latches the config,
//   waits cfg_ts settle cycles, then requests one sample every max(cfg_ti,1)
//   cycles. Each accepted sample is checked against a held reference level.
//   NO_BUFF consecutive in-tolerance samples declare steady-state (DONE).
//   Reaching cfg_max samples first declares a timeout (TOUT).
//
// Ports
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   start, abort         begin a run (IDLE/DONE/TOUT only) / return to IDLE
//   cfg_ts, cfg_ti       settle cycles, cycles between requests (0 -> 1)
//   cfg_tol              tolerance, unsigned magnitude
//   cfg_max              sample budget including the first (0 = unlimited)
//   smp_req/smp_vld/     sample handshake and data
//   smp_data
//   busy                 high in SETTLE/WAIT/REQ
//   steady, timeout      sticky result flags
//   ss_value             reference level, meaningful while steady
//   n_samples            samples accepted this run (saturating)
//   dbg_state            current FSM state (IDLE=0 .. TOUT=5)
//
// Handshake: smp_req is decoded from the state register only, so it never
// depends combinationally on smp_vld. A sample transfers on any rising edge
// where smp_req && smp_vld; smp_req then drops on the following cycle.
// smp_vld while smp_req is low is ignored.
// ---------------------------------------------------------------------------
module ss_meas_ctrl #(
  parameter int DW      = 16,
  parameter int CW      = 16,
  parameter int NO_BUFF = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_ts,
  input  logic [CW-1:0] cfg_ti,
  input  logic [DW-1:0] cfg_tol,
  input  logic [CW-1:0] cfg_max,
  output logic          smp_req,
  input  logic          smp_vld,
  input  logic [DW-1:0] smp_data,
  output logic          busy,
  output logic          steady,
  output logic          timeout,
  output logic [DW-1:0] ss_value,
  output logic [CW-1:0] n_samples,
  output logic [2:0]    dbg_state
);

  localparam int HW = $clog2(NO_BUFF + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(NO_BUFF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_WAIT   = 3'd2,
    S_REQ    = 3'd3,
    S_DONE   = 3'd4,
    S_TOUT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ts_q, ts_d;
  logic [CW-1:0]   ti_q, ti_d;
  logic [CW-1:0]   max_q, max_d;
  logic [DW-1:0]   tol_q, tol_d;
  logic [DW-1:0]   ref_q, ref_d;
  logic [DW-1:0]   ss_q, ss_d;
  logic [CW-1:0]   n_q, n_d;
  logic [HW-1:0]   hit_q, hit_d;

  logic            start_ok, accept, first_smp, in_tol, last_hit, budget_hit;
  logic            cnt_end;
  logic [CW-1:0]   ti_eff, cnt_lim, n_inc;
  logic [DW:0]     diff, abs_diff;

  // Datapath decode shared by next-state and register-update logic
  always_comb begin
    // One extra bit so full-scale opposite extremes cannot overflow.
    diff       = {smp_data[DW-1], smp_data} - {ref_q[DW-1], ref_q};
    abs_diff   = diff[DW] ? (~diff + 1'b1) : diff;
    in_tol     = abs_diff <= {1'b0, tol_q};
    ti_eff     = (ti_q == '0) ? CW'(1) : ti_q;
    cnt_lim    = (state_q == S_SETTLE) ? (ts_q - CW'(1)) : (ti_eff - CW'(1));
    cnt_end    = (cnt_q == cnt_lim);
    n_inc      = (n_q == '1) ? n_q : (n_q + CW'(1));
    first_smp  = (n_q == '0);
    last_hit   = !first_smp && in_tol && (hit_q == HIT_LAST);
    budget_hit = (max_q != '0) && (n_inc == max_q);
    start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                           (state_q == S_TOUT));
    accept     = (state_q == S_REQ) && smp_vld;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort outranks everything including start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TOUT:
          if (start) state_d = (cfg_ts != '0) ? S_SETTLE : S_WAIT;
        S_SETTLE:
          if (cnt_end) state_d = S_WAIT;
        S_WAIT:
          if (cnt_end) state_d = S_REQ;
        S_REQ:
          if (accept) begin
            // Steady-state beats the budget when both land on one sample.
            if (last_hit)        state_d = S_DONE;
            else if (budget_hit) state_d = S_TOUT;
            else                 state_d = S_WAIT;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Register next values
  always_comb begin
    ts_d  = ts_q;
    ti_d  = ti_q;
    max_d = max_q;
    tol_d = tol_q;
    ref_d = ref_q;
    ss_d  = ss_q;
    n_d   = n_q;
    hit_d = hit_q;
    // Interval counter restarts on every state change.
    cnt_d = ((state_d == state_q) &&
             ((state_q == S_SETTLE) || (state_q == S_WAIT))) ?
            (cnt_q + CW'(1)) : '0;
    if (abort) begin
      ss_d = '0;
    end else if (start_ok) begin
      ts_d  = cfg_ts;
      ti_d  = cfg_ti;
      max_d = cfg_max;
      tol_d = cfg_tol;
      ref_d = '0;
      ss_d  = '0;
      n_d   = '0;
      hit_d = '0;
    end else if (accept) begin
      n_d = n_inc;
      if (first_smp) begin
        ref_d = smp_data;
        hit_d = '0;
      end else if (in_tol) begin
        hit_d = hit_q + HW'(1);
        if (last_hit) ss_d = ref_q;
      end else begin
        hit_d = '0;
        ref_d = smp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      ts_q  <= '0;
      ti_q  <= '0;
      max_q <= '0;
      tol_q <= '0;
      ref_q <= '0;
      ss_q  <= '0;
      n_q   <= '0;
      hit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ts_q  <= ts_d;
      ti_q  <= ti_d;
      max_q <= max_d;
      tol_q <= tol_d;
      ref_q <= ref_d;
      ss_q  <= ss_d;
      n_q   <= n_d;
      hit_q <= hit_d;
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    smp_req   = (state_q == S_REQ);
    busy      = (state_q == S_SETTLE) || (state_q == S_WAIT) ||
                (state_q == S_REQ);
    steady    = (state_q == S_DONE);
    timeout   = (state_q == S_TOUT);
    ss_value  = ss_q;
    n_samples = n_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ss_meas_ctrl.sv
// Bench for ss_meas_ctrl: a table of complete runs plus hand-written
// sequences for abort, restart, stray valid and mid-run reset.
module tb_ss_meas_ctrl;

  localparam int DW = 16;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_ts = '0, cfg_ti = '0, cfg_max = '0;
  logic [DW-1:0] cfg_tol = '0;
  logic          smp_vld = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          smp_req, busy, steady, timeout;
  logic [DW-1:0] ss_value;
  logic [CW-1:0] n_samples;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  ss_meas_ctrl #(.DW(DW), .CW(CW), .NO_BUFF(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_ts(cfg_ts), .cfg_ti(cfg_ti), .cfg_tol(cfg_tol), .cfg_max(cfg_max),
    .smp_req(smp_req), .smp_vld(smp_vld), .smp_data(smp_data),
    .busy(busy), .steady(steady), .timeout(timeout),
    .ss_value(ss_value), .n_samples(n_samples), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  // Expected {steady, timeout, ss_value (0 unless steady), n_samples}
  logic [33:0] exp_q[$];
  logic [33:0] sb_exp, sb_act;
  logic        done_prev = 1'b0;
  logic        done_now;

  always @(negedge clk) begin
    done_now = steady | timeout;
    if (done_now && !done_prev) begin
      sb_act = {steady, timeout, (steady ? ss_value : 16'h0), n_samples};
      if (exp_q.size() == 0) begin
        check("unexpected_completion", sb_act, 34'h0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_result", sb_act, sb_exp);
      end
    end
    done_prev <= done_now;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] ts, input logic [15:0] ti,
                           input logic [15:0] tol, input logic [15:0] mx);
    cfg_ts = ts; cfg_ti = ti; cfg_tol = tol; cfg_max = mx;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for smp_req and check how many cycles it took.
  task automatic wait_req(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!smp_req && lat < 300) begin
      tick();
      lat++;
    end
    if (!smp_req) check({name, "_bound"}, 0, 1);
    else          check(name, lat, exp_lat);
  endtask

  task automatic give_sample(input logic [15:0] d);
    smp_vld = 1'b1;
    smp_data = d;
    tick();
    smp_vld = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [15:0] ts;
    logic [15:0] ti;
    logic [15:0] tol;
    logic [15:0] mx;
    int          n;
    logic        st;
    logic        to;
    logic [15:0] ss;
    logic [15:0] nn;
  } vec_t;

  localparam int NV = 6;
  vec_t        vecs [NV];
  logic [15:0] smp_tab [NV][8];

  task automatic run_vec(input int i);
    vec_t v;
    int   ti_eff;
    v = vecs[i];
    ti_eff = (v.ti == 0) ? 1 : int'(v.ti);
    start_run(v.ts, v.ti, v.tol, v.mx);
    exp_q.push_back({v.st, v.to, (v.st ? v.ss : 16'h0), v.nn});
    for (int k = 0; k < v.n; k++) begin
      wait_req((k == 0) ? int'(v.ts) + ti_eff : ti_eff,
               $sformatf("v%0d_lat%0d", i, k));
      give_sample(smp_tab[i][k]);
      check($sformatf("v%0d_reqdrop%0d", i, k), smp_req, 0);
    end
    // Result flags must already be up the cycle after the final accept.
    check($sformatf("v%0d_flags", i), {steady, timeout}, {v.st, v.to});
    repeat (5) tick();
    check($sformatf("v%0d_idle", i), {smp_req, busy}, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // ts, ti, tol, max, n, steady, timeout, ss_value, n_samples
    vecs[0] = '{16'd10, 16'd5, 16'd2, 16'd0, 6, 1'b1, 1'b0, 16'd150, 16'd6};
    smp_tab[0] = '{16'd100, 16'd150, 16'd151, 16'd152, 16'd150, 16'd149,
                   16'd0, 16'd0};
    vecs[1] = '{16'd3, 16'd2, 16'd2, 16'd4, 4, 1'b0, 1'b1, 16'd0, 16'd4};
    smp_tab[1] = '{16'd0, 16'd10, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd5, 5, 1'b1, 1'b0, 16'd7, 16'd5};
    smp_tab[2] = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0};
    vecs[3] = '{16'd2, 16'd1, 16'd100, 16'd0, 6, 1'b1, 1'b0, 16'h8000, 16'd6};
    smp_tab[3] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8001, 16'h8000, 16'h8002,
                   16'd0, 16'd0};
    vecs[4] = '{16'd4, 16'd3, 16'd5, 16'd8, 8, 1'b1, 1'b0, 16'd20, 16'd8};
    smp_tab[4] = '{16'hFFF6, 16'hFFF8, 16'hFFFB, 16'd20, 16'd23, 16'd18,
                   16'd25, 16'd24};
    vecs[5] = '{16'd1, 16'd2, 16'd0, 16'd3, 3, 1'b0, 1'b1, 16'd0, 16'd3};
    smp_tab[5] = '{16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

    // Reset state
    repeat (3) tick();
    check("reset_outputs",
          {smp_req, busy, steady, timeout, ss_value, n_samples, dbg_state},
          '0);
    rstn = 1'b1;
    tick();

    // Table of complete runs, back to back (each start taken from DONE/TOUT)
    for (int i = 0; i < NV; i++) run_vec(i);

    // Stray smp_vld outside REQ, then delayed smp_vld while in REQ
    start_run(16'd1, 16'd3, 16'd1, 16'd0);
    smp_vld = 1'b1; smp_data = 16'd999;
    tick(); tick();
    smp_vld = 1'b0;
    wait_req(2, "stray_lat");
    check("stray_ignored", n_samples, 0);
    for (int d = 0; d < 3; d++) begin
      tick();
      check($sformatf("req_held%0d", d), smp_req, 1);
    end
    give_sample(16'd50);
    check("delayed_reqdrop", smp_req, 0);
    check("delayed_one_sample", n_samples, 1);

    // Abort while in REQ
    wait_req(3, "abort_lat");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_req", {busy, smp_req, steady, timeout, dbg_state}, '0);

    // Reach DONE, then start+abort on the same cycle
    start_run(16'd0, 16'd1, 16'd0, 16'd0);
    exp_q.push_back({1'b1, 1'b0, 16'd3, 16'd5});
    for (int k = 0; k < 5; k++) begin
      wait_req(1, $sformatf("b_lat%0d", k));
      give_sample(16'd3);
    end
    check("b_steady", {steady, ss_value}, {1'b1, 16'd3});
    start = 1'b1; abort = 1'b1;
    cfg_ts = 16'd0; cfg_ti = 16'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start", {busy, smp_req, steady, timeout, dbg_state}, '0);
    tick();
    check("abort_start_stays_idle", busy, 0);

    // Start during SETTLE ignored; cfg changes mid-run ignored
    start_run(16'd20, 16'd2, 16'd0, 16'd2);
    exp_q.push_back({1'b0, 1'b1, 16'd0, 16'd2});
    repeat (3) tick();
    cfg_ts = 16'd0; cfg_ti = 16'd7; cfg_max = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(18, "settle_restart_ignored");
    give_sample(16'd5);
    wait_req(2, "ti_latched");
    give_sample(16'd9);
    check("c_flags", {steady, timeout}, 2'b01);

    // Reset mid-WAIT clears everything
    start_run(16'd0, 16'd10, 16'd0, 16'd0);
    wait_req(10, "d_lat");
    give_sample(16'd42);
    check("d_count", n_samples, 1);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    check("reset_mid_wait",
          {smp_req, busy, steady, timeout, ss_value, n_samples, dbg_state},
          '0);
    rstn = 1'b1;

    // Reset in REQ together with smp_vld: no sample taken
    start_run(16'd0, 16'd1, 16'd0, 16'd0);
    wait_req(1, "e_lat");
    rstn = 1'b0; smp_vld = 1'b1; smp_data = 16'd7;
    tick();
    smp_vld = 1'b0; rstn = 1'b1;
    check("reset_in_req", {smp_req, busy, n_samples}, '0);
    tick();
    check("reset_in_req_after", {busy, n_samples}, '0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
